// File: rtl/ram_arbiter_rr_pkg.sv
// Shared encodings for the RAM/MMIO round-robin arbiter: access sizes, default MMIO window,
// arbiter states and the round-robin pointer advance.
package ram_arbiter_rr_pkg;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

  localparam logic [63:0] DEF_MMIO_BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] DEF_MMIO_MASK = 64'hFFFF_FFFF_FFFF_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAM  = 2'd1,
    ST_MMIO = 2'd2
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned ch, input int unsigned n);
    return (ch + 1 >= n) ? 0 : ch + 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_fifo.sv
// Per-channel request FIFO: circular buffer whose pointers carry one extra wrap bit so
// full and empty can be told apart without a separate counter.
module arb_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [IW-1:0] wr_idx, rd_idx;

  generate
    if (DEPTH == 1) begin : g_one
      assign wr_idx = '0;
      assign rd_idx = '0;
      assign full   = (wr_q != rd_q);
    end else begin : g_many
      assign wr_idx = wr_q[IW-1:0];
      assign rd_idx = rd_q[IW-1:0];
      assign full   = (wr_q[PW-1] != rd_q[PW-1]) && (wr_idx == rd_idx);
    end
  endgenerate

  assign empty = (wr_q == rd_q);
  assign dout  = mem_q[rd_idx];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push && !full) begin
      mem_d[wr_idx] = din;
      wr_d          = wr_q + PW'(1);
    end
    if (pop && !empty) rd_d = rd_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/ram_arbiter_rr.sv
// N-channel round-robin arbiter in front of the single RAM port; heads that fall in the
// MMIO window are served in one cycle on the MMIO port instead.
module ram_arbiter_rr
  import ram_arbiter_rr_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter logic [AW-1:0] MMIO_BASE = AW'(DEF_MMIO_BASE),
  parameter logic [AW-1:0] MMIO_MASK = AW'(DEF_MMIO_MASK)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    i_req_valid,
  output logic [NUM_CH-1:0]    o_req_ready,
  input  logic [NUM_CH*AW-1:0] i_req_addr,
  input  logic [NUM_CH-1:0]    i_req_wen,
  input  logic [NUM_CH*DW-1:0] i_req_wdata,
  input  logic [NUM_CH*3-1:0]  i_req_size,
  output logic [NUM_CH-1:0]    o_rsp_valid,
  output logic [DW-1:0]        o_rsp_rdata,
  output logic                 o_mmio_valid,
  output logic                 o_mmio_wen,
  output logic [AW-1:0]        o_mmio_addr,
  output logic [DW-1:0]        o_mmio_wdata,
  input  logic [DW-1:0]        i_mmio_rdata,
  output logic                 o_ram_valid,
  output logic                 o_ram_wen,
  output logic [AW-1:0]        o_ram_addr,
  output logic [DW-1:0]        o_ram_wdata,
  output logic [2:0]           o_ram_size,
  input  logic                 i_ram_ready,
  input  logic [DW-1:0]        i_ram_rdata
);
  localparam int CW = $clog2(NUM_CH);
  localparam int FW = 1 + DW + AW + 3;

  // FIFO entry layout: {wen, wdata, addr, size}
  logic [NUM_CH-1:0][FW-1:0] fifo_din, head;
  logic [NUM_CH-1:0] full, empty, push, pop;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign fifo_din[g] = {i_req_wen[g], i_req_wdata[g*DW +: DW],
                            i_req_addr[g*AW +: AW], i_req_size[g*3 +: 3]};
      assign push[g] = i_req_valid[g] & ~full[g];

      arb_req_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push[g]),
        .pop   (pop[g]),
        .din   (fifo_din[g]),
        .dout  (head[g]),
        .full  (full[g]),
        .empty (empty[g])
      );
    end
  endgenerate

  assign o_req_ready = ~full;

  arb_state_e    state_q, state_d;
  logic [CW-1:0] grant_q, grant_d, rr_q, rr_d, grant;
  logic          grant_found;
  int            scan_idx;
  logic          ram_valid_q, ram_valid_d, ram_wen_q, ram_wen_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [2:0]    ram_size_q, ram_size_d;
  logic [FW-1:0] gnt_head, act_head;
  logic          gnt_hit;

  // First non-empty channel starting at the round-robin pointer.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    scan_idx    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = (int'(rr_q) + i) % NUM_CH;
      if (!grant_found && !empty[scan_idx]) begin
        grant_found = 1'b1;
        grant       = CW'(scan_idx);
      end
    end
  end

  assign gnt_head = head[grant];
  assign act_head = head[grant_q];
  assign gnt_hit  = ((gnt_head[3 +: AW] & MMIO_MASK) == MMIO_BASE);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_d         = rr_q;
    ram_valid_d  = ram_valid_q;
    ram_wen_d    = ram_wen_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_size_d   = ram_size_q;
    pop          = '0;
    o_rsp_valid  = '0;
    o_rsp_rdata  = '0;
    o_mmio_valid = 1'b0;
    o_mmio_wen   = 1'b0;
    o_mmio_addr  = '0;
    o_mmio_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          grant_d = grant;
          if (gnt_hit) begin
            state_d = ST_MMIO;
          end else begin
            state_d     = ST_RAM;
            ram_valid_d = 1'b1;
            ram_wen_d   = gnt_head[FW-1];
            ram_wdata_d = gnt_head[AW+3 +: DW];
            ram_addr_d  = gnt_head[3 +: AW];
            ram_size_d  = gnt_head[2:0];
          end
        end
      end
      ST_RAM: begin
        if (i_ram_ready) begin
          o_rsp_valid[grant_q] = 1'b1;
          o_rsp_rdata          = i_ram_rdata;
          pop[grant_q]         = 1'b1;
          rr_d                 = CW'(rr_next(32'(grant_q), NUM_CH));
          ram_valid_d          = 1'b0;
          state_d              = ST_IDLE;
        end
      end
      ST_MMIO: begin
        // Timer/CLINT answers in the same cycle, so the head is served straight from the FIFO.
        o_mmio_valid         = 1'b1;
        o_mmio_wen           = act_head[FW-1];
        o_mmio_wdata         = act_head[AW+3 +: DW];
        o_mmio_addr          = act_head[3 +: AW];
        o_rsp_valid[grant_q] = 1'b1;
        o_rsp_rdata          = i_mmio_rdata;
        pop[grant_q]         = 1'b1;
        rr_d                 = CW'(rr_next(32'(grant_q), NUM_CH));
        state_d              = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      ram_valid_q <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_size_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      ram_valid_q <= ram_valid_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_size_q  <= ram_size_d;
    end
  end

  assign o_ram_valid = ram_valid_q;
  assign o_ram_wen   = ram_wen_q;
  assign o_ram_addr  = ram_addr_q;
  assign o_ram_wdata = ram_wdata_q;
  assign o_ram_size  = ram_size_q;

endmodule
